// File: rtl/voice_mixer_if.sv
// Voice sample strobes into the mixer and the mixed sample strobe out of it.
// Handshake: every ready_* is a one-cycle valid qualifying its sample in that same cycle; no back-pressure exists in either direction.
interface voice_mixer_if;
  logic signed [15:0] sample_one;
  logic signed [15:0] sample_two;
  logic signed [15:0] sample_three;
  logic               ready_one;
  logic               ready_two;
  logic               ready_three;
  logic signed [15:0] mixed_sample;
  logic               mixed_ready;

  modport master (
    output sample_one, sample_two, sample_three,
    output ready_one, ready_two, ready_three,
    input  mixed_sample, mixed_ready
  );

  modport slave (
    input  sample_one, sample_two, sample_three,
    input  ready_one, ready_two, ready_three,
    output mixed_sample, mixed_ready
  );
endinterface

// File: rtl/voice_mixer.sv
// Three-voice collector/mixer with timeout, gain-scaled saturating sum and a
// per-emit linear gain fade.
module voice_mixer #(
  parameter int TIMEOUT   = 64,
  parameter int FADE_STEP = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           play,
  input  logic [2:0]     voice_enable,
  voice_mixer_if.slave   bus,
  output logic           clipped,
  output logic           timeout_seen,
  output logic [8:0]     gain,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SUM     = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [2:0]         pending_q;
  logic [2:0]         carry_q;
  logic signed [15:0] hold_q [3];
  logic signed [15:0] sample_in [3];
  logic [CW-1:0]      cnt_q;
  logic               tmo_q;

  logic [2:0]         strobe;
  logic [2:0]         pending_merged;
  logic               complete;
  logic               timed_out;
  logic               tmo_hit;

  logic signed [17:0] sum;
  logic signed [27:0] product;
  logic signed [27:0] scaled;
  logic signed [15:0] sat_val;
  logic               sat_hit;

  logic [9:0]         gain_up;
  logic [8:0]         gain_next;

  assign sample_in[0] = bus.sample_one;
  assign sample_in[1] = bus.sample_two;
  assign sample_in[2] = bus.sample_three;

  // Strobes of disabled voices are dropped outright, which also covers the all-disabled case.
  assign strobe         = {bus.ready_three, bus.ready_two, bus.ready_one} & voice_enable;
  assign pending_merged = pending_q | strobe;
  assign complete       = (voice_enable != 3'b000) && ((pending_merged & voice_enable) == voice_enable);
  assign timed_out      = (pending_q != 3'b000) && (cnt_q == CNT_LAST);
  assign state_dbg      = state_q;

  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    case (state_q)
      COLLECT: begin
        if (voice_enable == 3'b000) begin
          state_d = COLLECT;
        end else if (complete) begin
          state_d = SUM;
        end else if (timed_out) begin
          state_d = SUM;
          tmo_hit = 1'b1;
        end
      end
      SUM:     state_d = EMIT;
      EMIT:    state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      if (pending_q[i] && voice_enable[i]) begin
        sum = sum + 18'(hold_q[i]);
      end
    end
  end

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign product = 28'(sum) * 28'($signed({1'b0, gain}));
  assign scaled  = product >>> 8;

  always_comb begin
    sat_val = scaled[15:0];
    sat_hit = 1'b0;
    if (scaled > 28'sd32767) begin
      sat_val = 16'sh7fff;
      sat_hit = 1'b1;
    end else if (scaled < -28'sd32768) begin
      sat_val = 16'sh8000;
      sat_hit = 1'b1;
    end
  end

  assign gain_up = {1'b0, gain} + 10'(FADE_STEP);

  always_comb begin
    if (play) begin
      gain_next = (gain_up > 10'd256) ? 9'd256 : gain_up[8:0];
    end else begin
      gain_next = (gain < 9'(FADE_STEP)) ? 9'd0 : gain - 9'(FADE_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= COLLECT;
      pending_q        <= '0;
      carry_q          <= '0;
      cnt_q            <= '0;
      tmo_q            <= 1'b0;
      bus.mixed_sample <= '0;
      bus.mixed_ready  <= 1'b0;
      clipped          <= 1'b0;
      timeout_seen     <= 1'b0;
      gain             <= '0;
      for (int i = 0; i < 3; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      bus.mixed_ready <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (strobe[i]) begin
          hold_q[i] <= sample_in[i];
        end
      end
      case (state_q)
        COLLECT: begin
          if (voice_enable == 3'b000) begin
            pending_q <= '0;
            cnt_q     <= '0;
          end else if (state_d == SUM) begin
            pending_q <= pending_merged;
            cnt_q     <= '0;
            tmo_q     <= tmo_hit;
          end else begin
            pending_q <= pending_merged;
            if (pending_q != 3'b000) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        SUM: begin
          // Strobes seen here belong to the next collection, so they park in carry_q.
          bus.mixed_sample <= sat_val;
          clipped          <= clipped | sat_hit;
          carry_q          <= carry_q | strobe;
        end
        EMIT: begin
          bus.mixed_ready <= 1'b1;
          pending_q       <= carry_q | strobe;
          carry_q         <= '0;
          timeout_seen    <= timeout_seen | tmo_q;
          gain            <= gain_next;
        end
        default: begin
          pending_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: a transaction-style reference model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_voice_mixer;
  localparam int TIMEOUT   = 64;
  localparam int FADE_STEP = 4;

  logic       clk;
  logic       rst_n;
  logic       play;
  logic [2:0] voice_enable;
  logic       clipped;
  logic       timeout_seen;
  logic [8:0] gain;
  logic [1:0] state_dbg;

  int tests;
  int failures;
  bit chk_en;

  voice_mixer_if mix_if ();

  voice_mixer #(.TIMEOUT(TIMEOUT), .FADE_STEP(FADE_STEP)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .play         (play),
    .voice_enable (voice_enable),
    .bus          (mix_if),
    .clipped      (clipped),
    .timeout_seen (timeout_seen),
    .gain         (gain),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase 0 = gathering, 1 = the mixing edge, 2 = the emitting edge.
  int m_hold [3];
  bit [2:0] m_pend;
  bit [2:0] m_next;
  int m_age;
  int m_phase;
  bit m_by_timeout;
  int m_gain;
  int e_sample;
  bit e_ready;
  bit e_clip;
  bit e_tmo;

  function automatic int mix_value(input int total, input int g);
    int v;
    v = (total * g) >>> 8;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  always @(posedge clk) begin
    bit [2:0] s;
    bit [2:0] had;
    int total;
    int raw;
    int smp [3];
    s = {mix_if.ready_three, mix_if.ready_two, mix_if.ready_one} & voice_enable;
    smp[0] = mix_if.sample_one;
    smp[1] = mix_if.sample_two;
    smp[2] = mix_if.sample_three;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_hold[i] = 0;
      m_pend = 0; m_next = 0; m_age = 0; m_phase = 0; m_by_timeout = 0;
      m_gain = 0; e_sample = 0; e_ready = 0; e_clip = 0; e_tmo = 0;
    end else begin
      e_ready = 0;
      if (m_phase == 1) begin
        total = 0;
        for (int i = 0; i < 3; i++)
          if (m_pend[i] && voice_enable[i]) total += m_hold[i];
        raw = (total * m_gain) >>> 8;
        e_sample = mix_value(total, m_gain);
        if (raw != e_sample) e_clip = 1;
        m_next |= s;
        m_phase = 2;
      end else if (m_phase == 2) begin
        e_ready = 1;
        if (m_by_timeout) e_tmo = 1;
        if (play) m_gain = (m_gain + FADE_STEP > 256) ? 256 : m_gain + FADE_STEP;
        else      m_gain = (m_gain - FADE_STEP < 0) ? 0 : m_gain - FADE_STEP;
        m_pend = m_next | s;
        m_next = 0;
        m_phase = 0;
        m_age = 0;
      end else if (voice_enable == 3'b000) begin
        m_pend = 0;
        m_age = 0;
      end else begin
        had = m_pend;
        m_pend |= s;
        if ((m_pend & voice_enable) == voice_enable) begin
          m_phase = 1; m_by_timeout = 0; m_age = 0;
        end else if (had != 0) begin
          if (m_age == TIMEOUT - 1) begin
            m_phase = 1; m_by_timeout = 1; m_age = 0;
          end else begin
            m_age++;
          end
        end
      end
      for (int i = 0; i < 3; i++) if (s[i]) m_hold[i] = smp[i];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_mixed_ready", {31'b0, mix_if.mixed_ready}, int'(e_ready));
      check("cyc_mixed_sample", $signed(mix_if.mixed_sample), e_sample);
      check("cyc_gain", {23'b0, gain}, m_gain);
      check("cyc_clipped", {31'b0, clipped}, int'(e_clip));
      check("cyc_timeout_seen", {31'b0, timeout_seen}, int'(e_tmo));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit [2:0] m, input int a, input int b, input int c);
    mix_if.ready_one    = m[0];
    mix_if.ready_two    = m[1];
    mix_if.ready_three  = m[2];
    mix_if.sample_one   = 16'(a);
    mix_if.sample_two   = 16'(b);
    mix_if.sample_three = 16'(c);
    @(negedge clk);
    mix_if.ready_one   = 1'b0;
    mix_if.ready_two   = 1'b0;
    mix_if.ready_three = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int max_cyc, output int lat);
    lat = 0;
    while (!mix_if.mixed_ready && lat < max_cyc) begin
      @(negedge clk);
      lat++;
    end
    if (!mix_if.mixed_ready) begin
      tests++;
      failures++;
      $display("FAIL wait_ready: no mixed_ready within %0d cycles", max_cyc);
    end
  endtask

  task automatic emit_all(input int a, input int b, input int c);
    int lat;
    drive(3'b111, a, b, c);
    wait_ready(10, lat);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    int seen;
    tests = 0; failures = 0; chk_en = 0;
    rst_n = 1'b0; play = 1'b1; voice_enable = 3'b111;
    mix_if.ready_one = 0; mix_if.ready_two = 0; mix_if.ready_three = 0;
    mix_if.sample_one = 0; mix_if.sample_two = 0; mix_if.sample_three = 0;
    repeat (3) @(negedge clk);
    check("reset_sample", $signed(mix_if.mixed_sample), 0);
    check("reset_ready", {31'b0, mix_if.mixed_ready}, 0);
    check("reset_gain", {23'b0, gain}, 0);
    chk_en = 1;
    rst_n = 1'b1;

    // Fade up from silence.
    emit_all(100, 200, 300);
    check("fade_first_sample", $signed(mix_if.mixed_sample), 0);
    check("fade_first_gain", {23'b0, gain}, 4);
    emit_all(100, 200, 300);
    check("fade_second_gain", {23'b0, gain}, 8);
    repeat (62) emit_all(100, 200, 300);
    check("fade_top_gain", {23'b0, gain}, 256);
    emit_all(100, 200, 300);
    check("fade_hold_gain", {23'b0, gain}, 256);
    check("unity_sample", $signed(mix_if.mixed_sample), 600);

    // Staggered strobes on cycles 0, 3, 5.
    drive(3'b001, 1000, 0, 0);
    idle(2);
    drive(3'b010, 0, 2000, 0);
    idle(1);
    drive(3'b100, 0, 0, 3000);
    wait_ready(10, lat);
    check("stagger_emit_cycle", 5 + lat, 7);
    check("stagger_sample", $signed(mix_if.mixed_sample), 6000);

    // Saturation both ways.
    emit_all(20000, 20000, 20000);
    check("sat_pos_sample", $signed(mix_if.mixed_sample), 32767);
    check("sat_pos_clipped", {31'b0, clipped}, 1);
    emit_all(-20000, -20000, -20000);
    check("sat_neg_sample", $signed(mix_if.mixed_sample), -32768);

    // Overwrite of an already latched voice.
    drive(3'b001, 111, 0, 0);
    drive(3'b001, 222, 0, 0);
    drive(3'b110, 0, 10, 20);
    wait_ready(10, lat);
    check("overwrite_sample", $signed(mix_if.mixed_sample), 252);

    // Strobes during SUM/EMIT carry into the next collection.
    drive(3'b111, 10, 20, 30);
    drive(3'b001, 7, 0, 0);
    drive(3'b010, 0, 8, 0);
    check("carry_first_ready", {31'b0, mix_if.mixed_ready}, 1);
    check("carry_first_sample", $signed(mix_if.mixed_sample), 60);
    drive(3'b100, 0, 0, 9);
    wait_ready(10, lat);
    check("carry_latency", lat, 2);
    check("carry_second_sample", $signed(mix_if.mixed_sample), 24);

    // Timeout with only voice one.
    drive(3'b001, 500, 0, 0);
    wait_ready(80, lat);
    check("timeout_latency", lat, 66);
    check("timeout_sample", $signed(mix_if.mixed_sample), 500);
    check("timeout_flag", {31'b0, timeout_seen}, 1);

    // Fade down to half gain.
    play = 1'b0;
    repeat (32) emit_all(1, 1, 1);
    check("fade_half_gain", {23'b0, gain}, 128);

    // Only voice two enabled.
    voice_enable = 3'b010;
    drive(3'b101, 100, 0, 300);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (mix_if.mixed_ready) seen++;
    end
    check("disabled_no_emit", seen, 0);
    drive(3'b010, 0, -1200, 0);
    wait_ready(10, lat);
    check("single_voice_sample", $signed(mix_if.mixed_sample), -600);

    // Reset while in SUM aborts the mix; a coincident strobe is dropped.
    voice_enable = 3'b111;
    drive(3'b111, 1000, 2000, 3000);
    rst_n = 1'b0;
    mix_if.ready_one = 1'b1;
    mix_if.sample_one = 16'sd5555;
    @(negedge clk);
    mix_if.ready_one = 1'b0;
    rst_n = 1'b1;
    check("abort_ready", {31'b0, mix_if.mixed_ready}, 0);
    check("abort_sample", $signed(mix_if.mixed_sample), 0);
    check("abort_clipped", {31'b0, clipped}, 0);
    check("abort_timeout_seen", {31'b0, timeout_seen}, 0);
    check("abort_gain", {23'b0, gain}, 0);
    drive(3'b110, 0, 2000, 3000);
    wait_ready(80, lat);
    check("post_reset_latency", lat, 66);

    play = 1'b1;
    emit_all(1000, 2000, 3000);
    check("resume_first_sample", $signed(mix_if.mixed_sample), 0);
    emit_all(1000, 2000, 3000);
    check("resume_second_sample", $signed(mix_if.mixed_sample), 93);

    play = 1'b0;
    repeat (3) emit_all(1, 2, 3);
    check("fade_floor_gain", {23'b0, gain}, 0);

    idle(3);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $fatal(1, "watchdog");
  end
endmodule
